// File: rtl/count_pattern_pkg.sv
// Shared types and per-bit codes for the count pattern generator.
package count_pattern_pkg;

   typedef enum logic [1:0] {IDLE, CHECK, FILL, DONE} state_t;

   localparam logic [1:0] CODE_ZERO = 2'b00;
   localparam logic [1:0] CODE_ONE  = 2'b01;
   localparam logic [1:0] CODE_X    = 2'b10;
   localparam logic [1:0] CODE_Z    = 2'b11;

endpackage

// File: rtl/pattern_bit_classifier.sv
// Maps one bit position onto its category code from the fill thresholds.
module pattern_bit_classifier
   import count_pattern_pkg::*;
#(
   parameter int TW = 18
) (
   input  logic [TW-1:0] idx,
   input  logic [TW-1:0] t0,
   input  logic [TW-1:0] t1,
   input  logic [TW-1:0] t2,
   output logic [1:0]    code
);

   // Fill order zeros, ones, x, z; empty categories collapse to equal thresholds.
   always_comb begin
      code = CODE_Z;
      if (idx < t0)      code = CODE_ZERO;
      else if (idx < t1) code = CODE_ONE;
      else if (idx < t2) code = CODE_X;
   end

endmodule

// File: rtl/count_pattern_gen.sv
// Builds an N-bit 4-state vector holding the requested counts of 0/1/x/z bits,
// one position per clock, with a 2-bit-per-position code for synthesized use.
module count_pattern_gen
   import count_pattern_pkg::*;
#(
   parameter int N  = 20,
   parameter int CW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CW-1:0]     zeros_in,
   input  logic [CW-1:0]     ones_in,
   input  logic [CW-1:0]     xs_in,
   input  logic [CW-1:0]     zs_in,
   output logic              out_valid,
   input  logic              out_ready,
   output wire logic [N-1:0] pattern,
   output logic [2*N-1:0]    pattern_code,
   output logic              err
);

   localparam int TW = CW + 2;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [TW-1:0] N_T  = TW'(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   zeros_q, ones_q, xs_q, zs_q;
   logic [TW-1:0]   t0_q, t1_q, t2_q, sum;
   logic [IW-1:0]   idx_q;
   logic [2*N-1:0]  code_q;
   logic            err_q, out_valid_q;
   logic [1:0]      bit_code;

   // Widened so four full-scale counts cannot wrap back onto N.
   assign sum = TW'(zeros_q) + TW'(ones_q) + TW'(xs_q) + TW'(zs_q);

   assign req_ready    = (state_q == IDLE);
   assign out_valid    = out_valid_q;
   assign err          = err_q;
   assign pattern_code = code_q;

   pattern_bit_classifier #(.TW(TW)) u_cls (
      .idx  (TW'(idx_q)),
      .t0   (t0_q),
      .t1   (t1_q),
      .t2   (t2_q),
      .code (bit_code)
   );

   // Unwritten/cleared positions carry code 00, so they read back as 0.
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign pattern[i] = (code_q[2*i +: 2] == CODE_Z) ? 1'bz :
                          (code_q[2*i +: 2] == CODE_X) ? 1'bx : code_q[2*i];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: CHECK bypasses FILL when the counts do not add up to N.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (req_valid)                state_d = CHECK;
         CHECK: state_d = (sum != N_T) ? DONE : FILL;
         FILL:  if (idx_q == LAST)            state_d = DONE;
         DONE:  if (out_valid_q && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: count latch, thresholds, fill index, result and handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zeros_q     <= '0;
         ones_q      <= '0;
         xs_q        <= '0;
         zs_q        <= '0;
         t0_q        <= '0;
         t1_q        <= '0;
         t2_q        <= '0;
         idx_q       <= '0;
         code_q      <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               zeros_q <= zeros_in;
               ones_q  <= ones_in;
               xs_q    <= xs_in;
               zs_q    <= zs_in;
            end
            CHECK: begin
               t0_q   <= TW'(zeros_q);
               t1_q   <= TW'(zeros_q) + TW'(ones_q);
               t2_q   <= TW'(zeros_q) + TW'(ones_q) + TW'(xs_q);
               idx_q  <= '0;
               code_q <= '0;
               err_q  <= (sum != N_T);
            end
            FILL: begin
               code_q[{idx_q, 1'b0} +: 2] <= bit_code;
               if (idx_q != LAST) idx_q <= idx_q + IW'(1);
            end
            DONE: begin
               if (!out_valid_q)   out_valid_q <= 1'b1;
               else if (out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_count_pattern_gen.sv
// Randomized bench for count_pattern_gen with a queue-built reference model.
module tb_count_pattern_gen;

   localparam int N  = 20;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            out_ready = 1'b1;
   logic [CW-1:0]   zeros_in = '0, ones_in = '0, xs_in = '0, zs_in = '0;
   wire             req_ready, out_valid, err;
   wire  [N-1:0]    pattern;
   wire  [2*N-1:0]  pattern_code;

   count_pattern_gen #(.N(N), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .zeros_in(zeros_in), .ones_in(ones_in), .xs_in(xs_in), .zs_in(zs_in),
      .out_valid(out_valid), .out_ready(out_ready), .pattern(pattern),
      .pattern_code(pattern_code), .err(err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int fails   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference: lay the categories out in order through a queue.
   function automatic logic [2*N-1:0] build(input int z, input int o, input int x, input int zz);
      logic [1:0]     q[$];
      logic [2*N-1:0] r = '0;
      repeat (z)  q.push_back(2'b00);
      repeat (o)  q.push_back(2'b01);
      repeat (x)  q.push_back(2'b10);
      repeat (zz) q.push_back(2'b11);
      for (int i = 0; i < N; i++) r[2*i +: 2] = q[i];
      return r;
   endfunction

   // Model state: one outstanding request, its acceptance cycle and result.
   bit             busy = 0;
   int             cyc = 0, acc = 0, lat = 0;
   logic [2*N-1:0] m_code = '0;
   bit             m_err = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy = 0;
      end else begin
         bit v;
         int z, o, x, zz;
         v = busy && (cyc - acc >= lat);
         cyc++;
         if (busy) begin
            if (v && out_ready) busy = 0;
         end else if (req_valid) begin
            z = int'(zeros_in); o = int'(ones_in); x = int'(xs_in); zz = int'(zs_in);
            busy  = 1;
            acc   = cyc;
            m_err = (z + o + x + zz != N);
            lat   = m_err ? 2 : N + 2;
            m_code = m_err ? '0 : build(z, o, x, zz);
         end
      end
   end

   // Compare every cycle against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         bit             expv;
         int             w;
         logic [2*N-1:0] ec;
         logic [N-1:0]   pm, pe;
         expv = busy && (cyc - acc >= lat);
         chk("req_ready", 64'(req_ready), 64'(!busy));
         chk("out_valid", 64'(out_valid), 64'(expv));
         if (busy && (cyc - acc >= 1)) begin
            w  = m_err ? 0 : ((cyc - acc - 1 > N) ? N : cyc - acc - 1);
            ec = '0;
            for (int i = 0; i < w; i++) ec[2*i +: 2] = m_code[2*i +: 2];
            chk("pattern_code", 64'(pattern_code), 64'(ec));
         end
         if (expv) begin
            chk("err", 64'(err), 64'(m_err));
            pm = '0; pe = '0;
            for (int i = 0; i < N; i++)
               if (!m_code[2*i+1]) begin pm[i] = 1'b1; pe[i] = m_code[2*i]; end
            chk("pattern01", 64'(pattern & pm), 64'(pe));
         end
      end
   end

   task automatic do_req(input int z, input int o, input int x, input int zz,
                         input int hold, input bit noise, input int exp_lat,
                         input bit lit, input logic [2*N-1:0] lit_code,
                         input logic [N-1:0] lit_pat, input logic [N-1:0] lit_pm,
                         input bit lit_err);
      int k;
      @(posedge clk); #2;
      zeros_in = CW'(z); ones_in = CW'(o); xs_in = CW'(x); zs_in = CW'(zz);
      req_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #2;
      req_valid = 1'b0;
      zeros_in = CW'($urandom); ones_in = CW'($urandom);
      k = 0;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         if (k > 200) begin chk("timeout", 64'(k), 64'(exp_lat)); break; end
         if (noise && k >= 2 && k < 8) begin
            req_valid = $urandom_range(0, 1) != 0;
            zeros_in = CW'($urandom_range(0, N)); ones_in = CW'($urandom_range(0, N));
            xs_in = CW'($urandom_range(0, N));    zs_in = CW'($urandom_range(0, N));
         end else req_valid = 1'b0;
         k++;
      end
      req_valid = 1'b0;
      if (exp_lat >= 0) chk("latency", 64'(k), 64'(exp_lat));
      if (lit) begin
         chk("lit_code", 64'(pattern_code), 64'(lit_code));
         chk("lit_pattern", 64'(pattern & lit_pm), 64'(lit_pat));
         chk("lit_err", 64'(err), 64'(lit_err));
      end
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #2;
   endtask

   initial begin
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_code", 64'(pattern_code), 64'd0);
      chk("rst_pattern", 64'(pattern), 64'd0);
      #10 rst_n = 1'b1;

      do_req(5, 5, 5, 5, 0, 0, 22, 1, 40'hFFEAA55400, 20'h003E0, 20'h003FF, 0);
      do_req(5, 5, 5, 4, 0, 0, 2, 1, '0, '0, 20'hFFFFF, 1);
      do_req(32'hFFFF, 1, 0, 0, 0, 0, 2, 1, '0, '0, 20'hFFFFF, 1);
      do_req(0, 20, 0, 0, 0, 0, 22, 1, 40'h5555555555, 20'hFFFFF, 20'hFFFFF, 0);
      do_req(20, 0, 0, 0, 0, 0, 22, 1, '0, '0, 20'hFFFFF, 0);
      do_req(5, 5, 5, 5, 10, 0, 22, 0, '0, '0, '0, 0);
      do_req(1, 2, 3, 14, 0, 0, 22, 0, '0, '0, '0, 0);
      do_req(0, 0, 20, 0, 0, 0, 22, 0, '0, '0, '0, 0);
      do_req(7, 0, 0, 13, 0, 0, 22, 0, '0, '0, '0, 0);
      do_req(3, 4, 6, 7, 0, 1, 22, 0, '0, '0, '0, 0);

      // Reset while FILL is at index 7.
      @(posedge clk); #2;
      zeros_in = 16'd5; ones_in = 16'd5; xs_in = 16'd5; zs_in = 16'd5;
      req_valid = 1'b1;
      @(posedge clk); #2;
      req_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2 chk("fill_partial", 64'(pattern_code), 64'h1400);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_code", 64'(pattern_code), 64'd0);
      chk("abort_pattern", 64'(pattern), 64'd0);
      chk("abort_err", 64'(err), 64'd0);
      #5 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 64'(req_ready), 64'd1);

      for (int n = 0; n < 40; n++) begin
         int z, o, x, zz;
         if ($urandom_range(0, 3) != 0) begin
            z  = $urandom_range(0, N);
            o  = $urandom_range(0, N - z);
            x  = $urandom_range(0, N - z - o);
            zz = N - z - o - x;
         end else begin
            z  = $urandom_range(0, 3) == 0 ? 32'hFFFF : $urandom_range(0, 12);
            o  = $urandom_range(0, 12);
            x  = $urandom_range(0, 12);
            zz = $urandom_range(0, 12);
         end
         do_req(z, o, x, zz, $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                -1, 0, '0, '0, '0, 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
